// File: rtl/mag_comparator.sv
// Registered magnitude comparator: AiB (A<B), AeB (A==B), AsB (A>B) with a 1-cycle valid pipe.
// Define COMPARE_SIGNED_EN for a two's-complement compare (inverted MSB handling).

module compareCell #(
  parameter bit SignFlip = 1'b0
) (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic gt
);
  // A sign bit of 1 means a smaller value, so the MSB cell swaps its sense.
  assign lt = SignFlip ? (a & ~b) : (~a & b);
  assign gt = SignFlip ? (~a & b) : (a & ~b);
endmodule

module mag_comparator #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic             AiB,
  output logic             AeB,
  output logic             AsB
);
  localparam int STAGES = 1;

  logic [WIDTH-1:0] ltBit, gtBit;
  logic             ltAny, gtAny;
  logic [STAGES:0]  vldPipe;

  for (genvar i = 0; i < WIDTH; i++) begin : gCell
`ifdef COMPARE_SIGNED_EN
    localparam bit SignFlip = (i == WIDTH-1);
`else
    localparam bit SignFlip = 1'b0;
`endif
    compareCell #(.SignFlip(SignFlip)) uCell (
      .a (A[i]),
      .b (B[i]),
      .lt(ltBit[i]),
      .gt(gtBit[i])
    );
  end

  // Walk LSB to MSB so the most significant differing bit wins.
  always_comb begin
    ltAny = 1'b0;
    gtAny = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ltBit[i] | gtBit[i]) begin
        ltAny = ltBit[i];
        gtAny = gtBit[i];
      end
    end
  end

  assign vldPipe[0] = in_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vldPipe[STAGES:1] <= '0;
    else        vldPipe[STAGES:1] <= vldPipe[STAGES-1:0];
  end

  assign out_valid = vldPipe[STAGES];

  // Flags only load on a valid sample; otherwise they hold the last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AiB <= 1'b0;
      AeB <= 1'b0;
      AsB <= 1'b0;
    end else if (in_valid) begin
      AiB <= ltAny;
      AeB <= ~(ltAny | gtAny);
      AsB <= gtAny;
    end
  end
endmodule

// File: tb/tb_mag_comparator.sv
// Directed bench for mag_comparator at WIDTH 1, 8 and 16; packed checks are {out_valid,AiB,AeB,AsB}.

module tb_mag_comparator;
  localparam logic [3:0] ZR = 4'b0000;
  localparam logic [3:0] LT = 4'b1100;
  localparam logic [3:0] EQ = 4'b1010;
  localparam logic [3:0] GT = 4'b1001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        vi1, vi8, vi16;
  logic [0:0]  a1, b1;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        ov1, lt1, eq1, gt1;
  logic        ov8, lt8, eq8, gt8;
  logic        ov16, lt16, eq16, gt16;

  int total = 0;
  int bad = 0;

  mag_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vi1), .A(a1), .B(b1),
    .out_valid(ov1), .AiB(lt1), .AeB(eq1), .AsB(gt1));
  mag_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(vi8), .A(a8), .B(b8),
    .out_valid(ov8), .AiB(lt8), .AeB(eq8), .AsB(gt8));
  mag_comparator #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(vi16), .A(a16), .B(b16),
    .out_valid(ov16), .AiB(lt16), .AeB(eq16), .AsB(gt16));

  wire [3:0] o1  = {ov1, lt1, eq1, gt1};
  wire [3:0] o8  = {ov8, lt8, eq8, gt8};
  wire [3:0] o16 = {ov16, lt16, eq16, gt16};

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ref16(input logic [15:0] a, input logic [15:0] b);
    logic l, g;
`ifdef COMPARE_SIGNED_EN
    l = $signed(a) < $signed(b);
    g = $signed(a) > $signed(b);
`else
    l = a < b;
    g = a > b;
`endif
    return {l, ~(l | g), g};
  endfunction

  initial begin
    logic [3:0] exp16;
    logic [2:0] held16;
    logic       v;

    // Reset held with valid inputs present
    rst_n = 1'b0;
    vi1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    vi8 = 1'b1; a8 = 8'd3; b8 = 8'd1;
    vi16 = 1'b1; a16 = 16'd3; b16 = 16'd1;
    tick(); tick(); tick();
    chk("rst_w1", o1, ZR);
    chk("rst_w8", o8, ZR);
    chk("rst_w16", o16, ZR);

    rst_n = 1'b1;
    a1 = 1'b0; b1 = 1'b0;
    tick();
    chk("post_rst_w8", o8, GT);
    chk("post_rst_w16", o16, GT);
    chk("w1_00", o1, EQ);

    a1 = 1'b0; b1 = 1'b1;
    a8 = 8'h80; b8 = 8'h7F;
    vi16 = 1'b0;
    tick();
`ifdef COMPARE_SIGNED_EN
    chk("w1_01", o1, GT);
    chk("w8_80_7f", o8, LT);
`else
    chk("w1_01", o1, LT);
    chk("w8_80_7f", o8, GT);
`endif
    chk("w16_hold_novalid", o16, 4'b0001);

    a1 = 1'b1; b1 = 1'b0;
    a8 = 8'h00; b8 = 8'hFF;
    tick();
`ifdef COMPARE_SIGNED_EN
    chk("w1_10", o1, LT);
    chk("w8_00_ff", o8, GT);
`else
    chk("w1_10", o1, GT);
    chk("w8_00_ff", o8, LT);
`endif

    a1 = 1'b1; b1 = 1'b1;
    a8 = 8'hA5; b8 = 8'hA5;
    #2;
`ifdef COMPARE_SIGNED_EN
    chk("w8_no_early", o8, GT);
`else
    chk("w8_no_early", o8, LT);
`endif
    tick();
    chk("w1_11", o1, EQ);
    chk("w8_a5_a5", o8, EQ);

    // Hold: flags keep the last result while in_valid is low
    vi1 = 1'b0;
    a8 = 8'd5; b8 = 8'd9;
    tick();
    chk("hold_load", o8, LT);
    chk("w1_valid_drop", o1, 4'b0010);
    vi8 = 1'b0; a8 = 8'd9; b8 = 8'd5;
    tick();
    chk("hold_1", o8, 4'b0100);
    tick();
    chk("hold_2", o8, 4'b0100);
    vi8 = 1'b1;
    tick();
    chk("hold_resume", o8, GT);

    a8 = 8'hFF; b8 = 8'h01;
    tick();
`ifdef COMPARE_SIGNED_EN
    chk("w8_ff_01", o8, LT);
`else
    chk("w8_ff_01", o8, GT);
`endif

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_w8", o8, ZR);
    chk("async_rst_w1", o1, ZR);
    chk("async_rst_w16", o16, ZR);
    tick();
    rst_n = 1'b1;
    vi8 = 1'b0;

    // Random WIDTH=16 against a reference compare
    held16 = 3'b000;
    for (int n = 0; n < 1000; n++) begin
      v = 1'($urandom_range(0, 1));
      vi16 = v;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      if (n % 7 == 0) b16 = a16;
      if (v) held16 = ref16(a16, b16);
      exp16 = {v, held16};
      tick();
      chk("rand16", o16, exp16);
      if (ov16) begin
        total++;
        assert ($countones({lt16, eq16, gt16}) == 1) else begin
          bad++;
          $error("FAIL onehot16: got %b want one-hot", {lt16, eq16, gt16});
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mag_comparator.md
Name: mag_comparator

Overview:
- Registered unsigned magnitude comparator producing three mutually exclusive flags for A<B, A==B and A>B.
- Generalises the 1-bit transistor-level comparator cell to WIDTH bits.
  - AiB is the "A inferior" flag (A<B).
  - AsB is the "A superior" flag (A>B).
  - AeB is the NOR of AiB and AsB.
- Sits in the datapath as a single-cycle pipelined compare stage with a valid qualifier.

Parameters:
- WIDTH, 1, operand width in bits; legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B sampled at this clk edge when high.
- A  input  WIDTH  operand A (unsigned by default).
- B  input  WIDTH  operand B (unsigned by default).
- out_valid  output  1  registered in_valid; flags below are a fresh result when high.
- AiB  output  1  A < B.
- AeB  output  1  A == B.
- AsB  output  1  A > B.

Behaviour:
- Combinational core, bit i:
  - lt_i = ~A[i] & B[i]
  - gt_i = A[i] & ~B[i]
  - eq_i = ~(lt_i | gt_i)
- MSB-first priority reduction: the first bit (from MSB down) with lt_i or gt_i set decides AiB/AsB. If all eq_i are set, the result is equal.
- Clock and reset:
  - One clock domain.
  - Reset is asynchronous and active-low; it asserts immediately and is released synchronously to clk by the integrating system.
- Reset values:
  - out_valid=0, AiB=0, AeB=0, AsB=0.
  - AeB is explicitly 0 in reset, not 1.
- Latency: exactly 1 cycle. A/B/in_valid sampled at edge N; result visible after edge N and held until edge N+1.
- in_valid low at an edge:
  - out_valid goes to 0.
  - AiB/AeB/AsB hold their previous values.
  - Downstream must qualify with out_valid.
- Back-to-back in_valid: a new result every cycle, no bubbles, no backpressure.
- Invariant: whenever out_valid=1, exactly one of AiB, AeB, AsB is 1.
- Reset mid-operation: any in-flight result is discarded; all outputs return to 0 asynchronously. The first valid result appears one edge after the first in_valid sampled post-reset.
- Boundary cases:
  - A=B=0 gives AeB.
  - A=all-ones, B=0 gives AsB.
  - A=0, B=all-ones gives AiB.
  - WIDTH=1 must reduce to the cell truth table: (A,B)=00→AeB, 01→AiB, 10→AsB, 11→AeB.
- No X propagation from the hold path. Flags are plain flops with enable = in_valid.

Optional Feature:
- Macro COMPARE_SIGNED_EN.
- When defined:
  - A and B are treated as two's-complement.
  - MSB handling inverts: A[MSB]=1, B[MSB]=0 gives AiB; A[MSB]=0, B[MSB]=1 gives AsB.
  - Remaining bits compare unsigned.
  - For WIDTH=1: A=1 (−1), B=0 gives AiB.
- When not defined: pure unsigned compare as above. The signed logic is absent from the netlist.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1, A=3, B=1 → out_valid=0 and all flags 0. Assert rst_n=0 asynchronously mid-cycle → all outputs clear before the next edge.
- WIDTH=1 exhaustive, in_valid=1 each cycle, (A,B)=00,01,10,11 → next cycle flags AeB, AiB, AsB, AeB; out_valid=1 throughout.
- WIDTH=8 unsigned:
  - A=8'h80, B=8'h7F → AsB=1.
  - A=8'h00, B=8'hFF → AiB=1.
  - A=B=8'hA5 → AeB=1.
  - Each appears exactly 1 cycle after sampling.
- Hold: after A=5, B=9 (AiB=1), drop in_valid and change A=9, B=5 → out_valid=0 and AiB stays 1 until in_valid returns.
- One-hot: 1000 random WIDTH=16 vectors with in_valid random → whenever out_valid=1, flags match a reference compare and exactly one is set.
- COMPARE_SIGNED_EN, WIDTH=8: A=8'hFF (−1), B=8'h01 → AiB=1. Same vector without the macro → AsB=1.
